fetch_redirect_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch stage. Arbitrates PC-redirect sources each cycle: EX mispredict, ID jump and BHT predicted-taken. Drives the fetch stage's PC enable, PC load selects and redirect targets. Holds redirects that arrive while fetch is stalled, runs a halt/resume state machine, generates pipeline flushes and counts mispredicts. Sits between the hazard/branch logic and the fetch stage, and is the fetch stage's only source of control.

---
 rtl/fetch_redirect_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch-stage redirect arbiter with pending hold, halt FSM and mispredict counter
`ifndef IM_ADDR_NBIT
`define IM_ADDR_NBIT 32
`endif

module fetch_redirect_ctrl #(
  parameter int AW = `IM_ADDR_NBIT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          stall_if,
  input  logic          ex_mispred,
  input  logic [AW-1:0] ex_pc_new,
  input  logic          id_jump,
  input  logic [AW-1:0] id_pc_new,
  input  logic          bht_taken,
  input  logic [AW-1:0] bht_target,
  input  logic          halt_req,
  input  logic          resume,
  output logic          pc_en,
  output logic          pc_ld_wtg,
  output logic          pc_ld_bht,
  output logic [AW-1:0] wtg_pc_new,
  output logic [AW-1:0] bht_pc_new,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          halted,
  output logic [15:0]   mispred_cnt
);

  typedef enum logic {RUN, HALTED} state_e;

  // Kind encoding is ordered so that numeric compare equals priority compare.
  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_BHT  = 2'd1;
  localparam logic [1:0] K_ID   = 2'd2;
  localparam logic [1:0] K_EX   = 2'd3;

  state_e        state_q;
  logic          halted_q;
  logic          pend_valid_q, pend_valid_d;
  logic [1:0]    pend_kind_q, pend_kind_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [1:0]    live_k, pend_k, sel_k;
  logic [AW-1:0] live_pc;
  logic          use_pend, issue;

  always_comb begin
    live_k  = ex_mispred ? K_EX : id_jump ? K_ID : bht_taken ? K_BHT : K_NONE;
    live_pc = ex_mispred ? ex_pc_new : id_jump ? id_pc_new : bht_target;
    pend_k  = pend_valid_q ? pend_kind_q : K_NONE;
    use_pend = pend_k > live_k;
    sel_k   = use_pend ? pend_k : live_k;
    // A selected EX redirect, live or pending, overrides the hazard stall.
    issue   = en && (state_q == RUN) && (!stall_if || (sel_k == K_EX));

    pc_en       = issue;
    pc_ld_wtg   = issue && (sel_k == K_EX || sel_k == K_ID);
    pc_ld_bht   = issue && (sel_k == K_BHT);
    flush_if_id = issue && (sel_k == K_EX || sel_k == K_ID);
    flush_id_ex = issue && (sel_k == K_EX);
    wtg_pc_new  = (use_pend && pend_k != K_BHT) ? pend_pc_q :
                  (ex_mispred ? ex_pc_new : id_pc_new);
    bht_pc_new  = (use_pend && pend_k == K_BHT) ? pend_pc_q : bht_target;
    halted      = halted_q;
    mispred_cnt = cnt_q;

    pend_valid_d = pend_valid_q;
    pend_kind_d  = pend_kind_q;
    pend_pc_d    = pend_pc_q;
    cnt_d        = cnt_q;
    if (issue) begin
      pend_valid_d = 1'b0;
      if (sel_k == K_EX && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end else if (en && live_k != K_NONE && live_k >= pend_k) begin
      pend_valid_d = 1'b1;
      pend_kind_d  = live_k;
      pend_pc_d    = live_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      halted_q     <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= K_NONE;
      pend_pc_q    <= '0;
      cnt_q        <= 16'd0;
    end else if (en) begin
      pend_valid_q <= pend_valid_d;
      pend_kind_q  <= pend_kind_d;
      pend_pc_q    <= pend_pc_d;
      cnt_q        <= cnt_d;
      case (state_q)
        RUN: if (halt_req) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        HALTED: if (resume) begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - scoreboard bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, stall_if, ex_mispred, id_jump, bht_taken, halt_req, resume;
  logic [15:0] ex_pc_new, id_pc_new, bht_target;
  logic        pc_en, pc_ld_wtg, pc_ld_bht, flush_if_id, flush_id_ex, halted;
  logic [15:0] wtg_pc_new, bht_pc_new, mispred_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic        pc_en, ld_w, ld_b, f1, f2, hal;
    logic [15:0] wpc, bpc, cnt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.AW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .stall_if(stall_if),
    .ex_mispred(ex_mispred), .ex_pc_new(ex_pc_new),
    .id_jump(id_jump), .id_pc_new(id_pc_new),
    .bht_taken(bht_taken), .bht_target(bht_target),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .pc_ld_wtg(pc_ld_wtg), .pc_ld_bht(pc_ld_bht),
    .wtg_pc_new(wtg_pc_new), .bht_pc_new(bht_pc_new),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .halted(halted), .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask

  // Monitor: pops one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "pc_en", {15'd0, pc_en}, {15'd0, e.pc_en});
      chk(e.name, "pc_ld_wtg", {15'd0, pc_ld_wtg}, {15'd0, e.ld_w});
      chk(e.name, "pc_ld_bht", {15'd0, pc_ld_bht}, {15'd0, e.ld_b});
      chk(e.name, "flush_if_id", {15'd0, flush_if_id}, {15'd0, e.f1});
      chk(e.name, "flush_id_ex", {15'd0, flush_id_ex}, {15'd0, e.f2});
      chk(e.name, "halted", {15'd0, halted}, {15'd0, e.hal});
      chk(e.name, "mispred_cnt", mispred_cnt, e.cnt);
      if (e.ld_w) chk(e.name, "wtg_pc_new", wtg_pc_new, e.wpc);
      if (e.ld_b) chk(e.name, "bht_pc_new", bht_pc_new, e.bpc);
    end
  end

  // One cycle: drive inputs {en,stall,halt,resume}, requests, then push expectation.
  task automatic cyc(input string n, input logic [3:0] ctl,
                     input logic ex, input logic [15:0] xpc,
                     input logic id, input logic [15:0] ipc,
                     input logic bh, input logic [15:0] bpc,
                     input logic e_pcen, input logic e_ldw, input logic e_ldb,
                     input logic [15:0] e_wpc, input logic [15:0] e_bpc,
                     input logic e_f1, input logic e_f2, input logic e_hal,
                     input logic [15:0] e_cnt);
    exp_t e;
    {en, stall_if, halt_req, resume} = ctl;
    ex_mispred = ex; ex_pc_new = xpc;
    id_jump = id;    id_pc_new = ipc;
    bht_taken = bh;  bht_target = bpc;
    e.name = n; e.pc_en = e_pcen; e.ld_w = e_ldw; e.ld_b = e_ldb;
    e.wpc = e_wpc; e.bpc = e_bpc; e.f1 = e_f1; e.f2 = e_f2; e.hal = e_hal; e.cnt = e_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {en, stall_if, halt_req, resume} = 4'b1000;
    {ex_mispred, id_jump, bht_taken} = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  localparam logic [3:0] RUN_   = 4'b1000;
  localparam logic [3:0] STALL  = 4'b1100;
  localparam logic [3:0] HALT   = 4'b1010;
  localparam logic [3:0] HALTRS = 4'b1011;
  localparam logic [3:0] RES    = 4'b1001;
  localparam logic [3:0] OFF    = 4'b0000;

  initial begin
    int sat_cnt;
    do_reset();
    cyc("reset_idle",  RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd0);
    cyc("priority",    RUN_, 1,16'h100, 1,16'h200, 1,16'h300, 1,1,0,16'h100,16'h0,1,1,0,16'd0);
    cyc("prio_cnt",    RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd1);
    cyc("bht_live",    RUN_, 0,16'h0, 0,16'h0, 1,16'h300, 1,0,1,16'h0,16'h300,0,0,0,16'd1);
    cyc("stall_id",    STALL,0,16'h0, 1,16'h040, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,0,16'd1);
    cyc("pend_id_apply",RUN_,0,16'h0, 0,16'h0, 0,16'h0, 1,1,0,16'h040,16'h0,1,0,0,16'd1);
    cyc("stall_bht",   STALL,0,16'h0, 0,16'h0, 1,16'h080, 0,0,0,16'h0,16'h0,0,0,0,16'd1);
    cyc("ex_over_stall",STALL,1,16'h0C0,0,16'h0, 0,16'h0, 1,1,0,16'h0C0,16'h0,1,1,0,16'd1);
    cyc("bht_discard", RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("pend_bht2",   STALL,0,16'h0, 0,16'h0, 1,16'h080, 0,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("id_replace",  STALL,0,16'h0, 1,16'h050, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("bht_noreplace",STALL,0,16'h0,0,16'h0, 1,16'h090, 0,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("replace_apply",RUN_,0,16'h0, 0,16'h0, 0,16'h0, 1,1,0,16'h050,16'h0,1,0,0,16'd2);
    cyc("pend_cleared",RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("pend_id_eq",  STALL,0,16'h0, 1,16'h060, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("live_eq_wins",RUN_, 0,16'h0, 1,16'h070, 0,16'h0, 1,1,0,16'h070,16'h0,1,0,0,16'd2);
    cyc("eq_cleared",  RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("halt_issue",  HALTRS,0,16'h0,0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("halted_id",   RUN_, 0,16'h0, 1,16'h010, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,1,16'd2);
    cyc("resume",      RES,  0,16'h0, 0,16'h0, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,1,16'd2);
    cyc("resume_apply",RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,1,0,16'h010,16'h0,1,0,0,16'd2);
    cyc("after_resume",RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("en_off_ex",   OFF,  1,16'h111,0,16'h0, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("en_off_after",RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("halt2",       HALT, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd2);
    cyc("halted_pend", RUN_, 0,16'h0, 1,16'h020, 0,16'h0, 0,0,0,16'h0,16'h0,0,0,1,16'd2);
    do_reset();
    cyc("post_reset",  RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'd0);
    sat_cnt = 0;
    for (int i = 0; i < 65536; i++) begin
      cyc("sat_ex", RUN_, 1,16'h0AA, 0,16'h0, 0,16'h0, 1,1,0,16'h0AA,16'h0,1,1,0,sat_cnt[15:0]);
      if (sat_cnt < 16'hFFFF) sat_cnt++;
    end
    cyc("sat_hold",    RUN_, 0,16'h0, 0,16'h0, 0,16'h0, 1,0,0,16'h0,16'h0,0,0,0,16'hFFFF);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
